// File: rtl/dma_burst_writer.sv
// Memory-to-bus DMA path: streams words from the CI scratchpad (SSRAM port B) to bus
// memory as burst write transactions, re-arbitrating for the bus before every burst.
module dma_burst_writer #(
   parameter int unsigned ssram_address_width = 9,
   parameter int unsigned block_size_width    = 10
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [31:0]                    bus_start_address,
   input  logic [ssram_address_width-1:0] memory_start_address,
   input  logic [block_size_width-1:0]    block_size,
   input  logic [7:0]                     burst_size,
   output logic                           busy,
   output logic                           error,
   output logic [ssram_address_width-1:0] ssram_address,
   input  logic [31:0]                    ssram_data,
   output logic                           request,
   input  logic                           granted,
   output logic [31:0]                    address_data_out,
   output logic [3:0]                     byte_enables_out,
   output logic [7:0]                     burst_size_out,
   output logic                           read_n_write_out,
   output logic                           begin_transaction_out,
   output logic                           end_transaction_out,
   output logic                           data_valid_out,
   input  logic                           busy_in,
   input  logic                           error_in
);

   // burst_size + 1 reaches 256, so burst arithmetic needs at least 9 bits
   localparam int unsigned len_width = (block_size_width > 9) ? block_size_width : 9;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQUEST,
      S_BEGIN,
      S_DATA,
      S_END,
      S_ERROR
   } state_t;

   state_t state_q, state_d;

   logic [31:0]                    bus_addr_q;
   logic [ssram_address_width-1:0] mem_addr_q;
   logic [block_size_width-1:0]    remaining_q;
   logic [7:0]                     burst_q;
   logic [len_width-1:0]           count_q;
   logic [31:0]                    hold_q;
   logic                           hold_valid_q;
   logic [31:0]                    begin_address_q;

   logic [len_width-1:0] burst_len;
   logic [len_width-1:0] rem_len;
   logic [len_width-1:0] len;
   logic                 last_word;

   logic        busy_d;
   logic        request_d;
   logic        begin_d;
   logic        end_d;
   logic        valid_d;
   logic [3:0]  byte_enables_d;
   logic [7:0]  burst_size_d;
   logic [31:0] begin_address_d;

   // Current burst length: full burst, or whatever is left of the block
   always_comb begin
      burst_len = len_width'(burst_q) + len_width'(1);
      rem_len   = len_width'(remaining_q);
      len       = (burst_len < rem_len) ? burst_len : rem_len;
      last_word = (count_q == (len - len_width'(1)));
   end

   // Next-state decode and next values of the registered bus outputs
   always_comb begin
      state_d         = state_q;
      busy_d          = 1'b0;
      request_d       = 1'b0;
      begin_d         = 1'b0;
      end_d           = 1'b0;
      valid_d         = 1'b0;
      byte_enables_d  = 4'b0000;
      burst_size_d    = 8'd0;
      begin_address_d = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (start && (block_size != '0)) state_d = S_REQUEST;
         end
         S_REQUEST: begin
            if (granted) state_d = S_BEGIN;
         end
         S_BEGIN: begin
            state_d = error_in ? S_ERROR : S_DATA;
         end
         S_DATA: begin
            if (error_in)                  state_d = S_ERROR;
            else if (!busy_in && last_word) state_d = S_END;
         end
         S_END: begin
            state_d = (rem_len == len) ? S_IDLE : S_REQUEST;
         end
         S_ERROR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d    = (state_d != S_IDLE);
      request_d = (state_d == S_REQUEST);
      begin_d   = (state_d == S_BEGIN);
      end_d     = (state_d == S_END);
      valid_d   = (state_d == S_DATA);
      if (state_d == S_BEGIN) begin
         byte_enables_d  = 4'b1111;
         burst_size_d    = 8'(len - len_width'(1));
         begin_address_d = bus_addr_q;
      end
   end

   // State, working copies, prefetch pipeline and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q               <= S_IDLE;
         bus_addr_q            <= 32'd0;
         mem_addr_q            <= '0;
         remaining_q           <= '0;
         burst_q               <= 8'd0;
         count_q               <= '0;
         hold_q                <= 32'd0;
         hold_valid_q          <= 1'b0;
         begin_address_q       <= 32'd0;
         busy                  <= 1'b0;
         error                 <= 1'b0;
         request               <= 1'b0;
         begin_transaction_out <= 1'b0;
         end_transaction_out   <= 1'b0;
         data_valid_out        <= 1'b0;
         byte_enables_out      <= 4'b0000;
         burst_size_out        <= 8'd0;
         ssram_address         <= '0;
      end else begin
         state_q               <= state_d;
         busy                  <= busy_d;
         request               <= request_d;
         begin_transaction_out <= begin_d;
         end_transaction_out   <= end_d;
         data_valid_out        <= valid_d;
         byte_enables_out      <= byte_enables_d;
         burst_size_out        <= burst_size_d;
         begin_address_q       <= begin_address_d;

         if ((state_q == S_IDLE) && start) begin
            bus_addr_q  <= bus_start_address;
            mem_addr_q  <= memory_start_address;
            remaining_q <= block_size;
            burst_q     <= burst_size;
            error       <= 1'b0;
         end else if (state_d == S_ERROR) begin
            error <= 1'b1;
         end

         case (state_q)
            S_REQUEST: begin
               ssram_address <= mem_addr_q;
               count_q       <= '0;
               hold_valid_q  <= 1'b0;
            end
            S_BEGIN: begin
               ssram_address <= mem_addr_q + ssram_address_width'(1);
            end
            S_DATA: begin
               // ssram_address runs one word ahead; a stall parks the in-flight word in hold_q
               if (!error_in) begin
                  if (!busy_in) begin
                     mem_addr_q    <= mem_addr_q + ssram_address_width'(1);
                     ssram_address <= ssram_address + ssram_address_width'(1);
                     count_q       <= count_q + len_width'(1);
                     hold_valid_q  <= 1'b0;
                  end else if (!hold_valid_q) begin
                     hold_q       <= ssram_data;
                     hold_valid_q <= 1'b1;
                  end
               end
            end
            S_END: begin
               bus_addr_q  <= bus_addr_q + (32'(len) << 2);
               remaining_q <= remaining_q - block_size_width'(len);
            end
            default: begin
            end
         endcase
      end
   end

   // Write data comes straight from the scratchpad (or the stall holding word)
   assign address_data_out = (state_q == S_DATA) ? (hold_valid_q ? hold_q : ssram_data)
                                                 : begin_address_q;
   assign read_n_write_out = 1'b0;

endmodule

// File: tb/tb_dma_burst_writer.sv
// Directed bench for dma_burst_writer: scratchpad model, table of transfers with
// grant delay / stall / error injection, plus reset corner sequences.
module tb_dma_burst_writer;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] bus_start_address;
   logic [8:0]  memory_start_address;
   logic [9:0]  block_size;
   logic [7:0]  burst_size;
   logic        busy;
   logic        error;
   logic [8:0]  ssram_address;
   logic [31:0] ssram_data;
   logic        request;
   logic        granted;
   logic [31:0] address_data_out;
   logic [3:0]  byte_enables_out;
   logic [7:0]  burst_size_out;
   logic        read_n_write_out;
   logic        begin_transaction_out;
   logic        end_transaction_out;
   logic        data_valid_out;
   logic        busy_in;
   logic        error_in;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [512];

   always #5 clock = ~clock;

   dma_burst_writer dut (
      .clock                 (clock),
      .reset                 (reset),
      .start                 (start),
      .bus_start_address     (bus_start_address),
      .memory_start_address  (memory_start_address),
      .block_size            (block_size),
      .burst_size            (burst_size),
      .busy                  (busy),
      .error                 (error),
      .ssram_address         (ssram_address),
      .ssram_data            (ssram_data),
      .request               (request),
      .granted               (granted),
      .address_data_out      (address_data_out),
      .byte_enables_out      (byte_enables_out),
      .burst_size_out        (burst_size_out),
      .read_n_write_out      (read_n_write_out),
      .begin_transaction_out (begin_transaction_out),
      .end_transaction_out   (end_transaction_out),
      .data_valid_out        (data_valid_out),
      .busy_in               (busy_in),
      .error_in              (error_in)
   );

   // Synchronous-read scratchpad: data one cycle after the address
   always @(posedge clock) ssram_data <= mem[ssram_address];

   typedef struct {
      int          block;
      int          burst;
      int          mem_start;
      logic [31:0] bus_start;
      int          grant_delay;
      int          stall_word;
      int          stall_len;
      int          err_word;
      bit          poke;
      int          exp_cycles;
      int          exp_words;
      int          exp_bursts;
      int          exp_ends;
      bit          exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  words, bursts, ends, rises, cycles, req_wait, stall_cnt, exp_len;
      logic prev_req;
      bit  done;
      words = 0; bursts = 0; ends = 0; rises = 0; cycles = 0;
      req_wait = 0; stall_cnt = 0; prev_req = 1'b0; done = 1'b0;

      @(negedge clock);
      block_size           = 10'(v.block);
      burst_size           = 8'(v.burst);
      memory_start_address = 9'(v.mem_start);
      bus_start_address    = v.bus_start;
      start                = 1'b1;

      for (int k = 0; k < 400; k++) begin
         @(negedge clock);
         busy_in  = 1'b0;
         error_in = 1'b0;
         if (k == 0) begin
            start = 1'b0;
            chk($sformatf("v%0d error_cleared", idx), 32'(error), 32'd0);
            chk($sformatf("v%0d request_latency", idx), 32'(request), 32'(v.block != 0));
         end
         if (v.poke && k == 2) begin
            start      = 1'b1;
            block_size = 10'd9;
         end
         if (v.poke && k == 3) start = 1'b0;
         if (!busy) begin
            done = 1'b1;
            break;
         end
         cycles++;
         chk($sformatf("v%0d rnw", idx), 32'(read_n_write_out), 32'd0);

         if (request && !prev_req) rises++;
         prev_req = request;
         granted  = request && (req_wait >= v.grant_delay);
         if (request) req_wait++;
         else req_wait = 0;

         if (begin_transaction_out) begin
            bursts++;
            exp_len = (v.burst + 1 < v.block - words) ? v.burst + 1 : v.block - words;
            chk($sformatf("v%0d begin_addr", idx), address_data_out, v.bus_start + 32'(4 * words));
            chk($sformatf("v%0d burst_size_out", idx), 32'(burst_size_out), 32'(exp_len - 1));
            chk($sformatf("v%0d byte_enables", idx), 32'(byte_enables_out), 32'hf);
         end else begin
            chk($sformatf("v%0d idle_be_bso", idx), {20'd0, byte_enables_out, burst_size_out}, 32'd0);
         end

         if (data_valid_out) begin
            chk($sformatf("v%0d data_w%0d", idx, words), address_data_out,
                mem[(v.mem_start + words) % 512]);
            error_in = (words == v.err_word);
            busy_in  = (words == v.stall_word) && (stall_cnt < v.stall_len);
            if (busy_in) stall_cnt++;
            if (!busy_in && !error_in) words++;
         end

         if (end_transaction_out) begin
            ends++;
            chk($sformatf("v%0d end_no_valid", idx), 32'(data_valid_out), 32'd0);
         end
      end

      busy_in  = 1'b0;
      error_in = 1'b0;
      granted  = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL v%0d timeout: busy=%0b after 400 cycles, required 0", idx, busy);
      end
      chk($sformatf("v%0d cycles", idx), 32'(cycles), 32'(v.exp_cycles));
      chk($sformatf("v%0d words", idx), 32'(words), 32'(v.exp_words));
      chk($sformatf("v%0d bursts", idx), 32'(bursts), 32'(v.exp_bursts));
      chk($sformatf("v%0d request_rises", idx), 32'(rises), 32'(v.exp_bursts));
      chk($sformatf("v%0d ends", idx), 32'(ends), 32'(v.exp_ends));
      chk($sformatf("v%0d error", idx), 32'(error), 32'(v.exp_err));
      repeat (2) begin
         @(negedge clock);
         chk($sformatf("v%0d stays_idle", idx), {30'd0, busy, request}, 32'd0);
      end
   endtask

   initial begin
      int seen;
      for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);

      //           blk brs mem  bus           gd  stall len err poke cyc wds bur end err
      vecs[0]  = '{4,  3,  16,  32'h1000_0000, 0, -1,  0, -1, 1'b0,  7,  4, 1, 1, 1'b0};
      vecs[1]  = '{10, 3,  32,  32'h2000_0100, 0, -1,  0, -1, 1'b0, 19, 10, 3, 3, 1'b0};
      vecs[2]  = '{4,  3,  64,  32'h3000_0000, 0,  2,  3, -1, 1'b0, 10,  4, 1, 1, 1'b0};
      vecs[3]  = '{4,  3,  510, 32'h4000_0000, 0, -1,  0, -1, 1'b0,  7,  4, 1, 1, 1'b0};
      vecs[4]  = '{8,  3,  80,  32'h5000_0000, 0,  1,  1,  1, 1'b0,  5,  1, 1, 0, 1'b1};
      vecs[5]  = '{3,  7,  96,  32'h6000_0000, 0, -1,  0, -1, 1'b0,  6,  3, 1, 1, 1'b0};
      vecs[6]  = '{0,  3,  100, 32'h6100_0000, 0, -1,  0, -1, 1'b0,  0,  0, 0, 0, 1'b0};
      vecs[7]  = '{10, 3,  112, 32'hFFFF_FFF0, 2, -1,  0, -1, 1'b0, 25, 10, 3, 3, 1'b0};
      vecs[8]  = '{3,  0,  128, 32'h7000_0000, 0, -1,  0, -1, 1'b0, 12,  3, 3, 3, 1'b0};
      vecs[9]  = '{6,  3,  144, 32'h7100_0000, 0,  3,  2, -1, 1'b0, 14,  6, 2, 2, 1'b0};
      vecs[10] = '{8,  3,  200, 32'h7200_0000, 0, -1,  0,  4, 1'b0, 11,  4, 2, 1, 1'b1};
      vecs[11] = '{4,  3,  160, 32'h7300_0000, 0, -1,  0, -1, 1'b1,  7,  4, 1, 1, 1'b0};

      reset = 1'b1; start = 1'b1; block_size = 10'd4; burst_size = 8'd3;
      memory_start_address = 9'd0; bus_start_address = 32'd0;
      granted = 1'b0; busy_in = 1'b0; error_in = 1'b0;
      repeat (3) @(negedge clock);
      chk("reset busy_request_error", {29'd0, busy, request, error}, 32'd0);
      chk("reset bus_controls", {17'd0, byte_enables_out, burst_size_out, data_valid_out,
          begin_transaction_out, end_transaction_out}, 32'd0);
      chk("reset address_data_out", address_data_out, 32'd0);
      chk("reset ssram_address", 32'(ssram_address), 32'd0);
      reset = 1'b0; start = 1'b0;
      @(negedge clock);
      chk("start_under_reset ignored", 32'(busy), 32'd0);

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Reset in the middle of a data phase aborts without an end cycle
      @(negedge clock);
      block_size = 10'd8; burst_size = 8'd7; memory_start_address = 9'd256;
      bus_start_address = 32'h8000_0000; granted = 1'b1; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      seen = 0;
      for (int k = 0; k < 20 && seen < 2; k++) begin
         if (data_valid_out) seen++;
         if (seen < 2) @(negedge clock);
      end
      chk("mid_reset reached_data", 32'(seen), 32'd2);
      reset = 1'b1;
      @(negedge clock);
      chk("mid_reset busy_request_error", {29'd0, busy, request, error}, 32'd0);
      chk("mid_reset bus_controls", {17'd0, byte_enables_out, burst_size_out, data_valid_out,
          begin_transaction_out, end_transaction_out}, 32'd0);
      chk("mid_reset address_data_out", address_data_out, 32'd0);
      chk("mid_reset ssram_address", 32'(ssram_address), 32'd0);
      reset = 1'b0; granted = 1'b0;
      repeat (3) begin
         @(negedge clock);
         chk("post_reset quiet", {30'd0, busy, end_transaction_out}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
